// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers (shift-add multiply, restoring divide).
// Optional single-cycle multiplier enabled by defining MDU_FAST_MULT_EN.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;

    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        opb_d     = opb_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;

        signed_op = ~op[0];
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        abs_a     = a_neg ? -a : a;
        abs_b     = b_neg ? -b : b;

        // One multiplier bit per step: add multiplicand into the upper half, then shift right
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        // Extra remainder bit keeps the trial subtract exact for full-range unsigned divisors
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_ge    = div_shift >= {2'b00, opb_q};
        div_diff  = div_shift - {2'b00, opb_q};
        prod      = neg_res_q ? -acc_q : acc_q;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    if (op <= 3'd3) begin
                        acc_d     = {{WIDTH{1'b0}}, abs_a};
                        opb_d     = abs_b;
                        rem_d     = '0;
                        cnt_d     = '0;
                        is_div_d  = op[1];
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        busy_d    = 1'b1;
                        state_d   = CALC;
`ifdef MDU_FAST_MULT_EN
                        if (!op[1]) begin
                            acc_d   = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
                            state_d = FIXUP;
                        end
`endif
                    end else if (op == 3'd4) begin
                        hi_d = a;
                    end else if (op == 3'd5) begin
                        lo_d = a;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        rem_d             = div_ge ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
                        acc_d[WIDTH-1:0]  = {acc_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = FIXUP;
                    end
                end
            end
            FIXUP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        hi_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            opb_q     <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            opb_q     <= opb_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers. Sits in the execute stage directly downstream of the three-ported register file.
- Operands come from the file's rd1/rd2 (rs/rt).
- Results are readable via hi/lo for MFHI/MFLO.
- The pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op
- a  input  WIDTH  operand rs (rd1)
- b  input  WIDTH  operand rt (rd2)
- flush  input  1  abort in-flight operation
- busy  output  1  operation in progress; pipeline stalls on MFHI/MFLO or a new mul/div
- done  output  1  one-cycle pulse; HI/LO updated this cycle
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0; iteration counter and internal accumulators cleared. Reset mid-operation discards the operation.
- States: IDLE, CALC, FIXUP.
- IDLE, start=1, op in 0..3 at edge E0:
  - Latch |a| and |b| (plain a and b for unsigned ops).
  - Latch result sign: a[31]^b[31] for the quotient/product; a[31] for the remainder.
  - Counter=0; go to CALC; busy=1 from the cycle after E0.
- IDLE, start=1, op=4: hi<=a at E0. op=5: lo<=a at E0.
  - No busy, no done.
  - The new value is visible on hi/lo the cycle after E0.
- op 6/7: ignored.
- CALC, multiply: shift-add; one bit of the multiplier per cycle into a 2*WIDTH accumulator.
- CALC, divide: restoring division; one quotient bit per cycle; the remainder register is WIDTH+1 bits so the trial subtract is correct for unsigned 0xFFFFFFFF.
- CALC exit: after exactly WIDTH cycles (edges E1..E32), go to FIXUP.
- FIXUP (edge E33):
  - Apply two's-complement negation per the latched signs.
  - Write hi/lo: product high/low, or remainder/quotient.
  - done=1 for the cycle after E33; busy=0 in that same cycle; return to IDLE.
- Total: busy high 33 cycles; results visible 34 cycles after the start edge.
- start while busy: ignored; not queued.
- done and a new start in the same cycle: legal; the new op is accepted (busy=0 then).
- flush=1 in CALC/FIXUP: return to IDLE next edge; hi/lo unchanged; no done pulse. flush in IDLE: no effect.
- flush and start in the same IDLE cycle: flush wins; nothing accepted.
- Divide by zero (b=0): no trap.
  - DIVU: lo=0xFFFFFFFF, hi=a.
  - DIV: lo=0xFFFFFFFF if a>=0, else 0x00000001; hi=a.
  - Same latency as a normal divide.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps); no exception.
- Remainder sign always follows the dividend. Quotient truncates toward zero.
- hi/lo change only at FIXUP, MTHI/MTLO, or reset.

Optional Feature:
- Macro MDU_FAST_MULT_EN.
- Defined:
  - MULT/MULTU compute in one cycle via a full WIDTH×WIDTH multiplier.
  - IDLE→FIXUP directly; busy high 1 cycle; done pulses 2 cycles after the start edge.
  - Divide is unchanged.
- Undefined: iterative 33-cycle multiply as above; no hardware multiplier inferred.

Test Plan:
- Reset: assert rst_n=0 mid-CALC of a DIVU -> busy=0, done=0, hi=lo=0 immediately (asynchronous); no done afterwards.
- MULT a=0xFFFFFFFE (-2), b=0x00000003 -> after 34 cycles done=1; hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with MULTU -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=0xFFFFFFFF, b=0x10 -> lo=0x0FFFFFFF, hi=0xF.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start a MULT, pulse start with DIVU while busy, then flush at CALC cycle 10:
  - second start ignored;
  - after flush: IDLE, no done, hi/lo keep prior values.
- MTHI a=0xDEADBEEF then MTLO a=0x0BADF00D on consecutive cycles -> hi/lo hold those values; busy stays 0; done stays 0.
- With MDU_FAST_MULT_EN: MULTU 0x10000 × 0x10000 -> done 2 cycles after start; hi=0x1, lo=0.
